sseg_capture: RTL

Receive-side counterpart of the four-digit seven-segment display path. It observes a time-multiplexed `an`/`sseg` bus as produced by the display multiplexer, waits for each digit strobe to settle, and captures that digit's segment pattern. Each captured pattern is decoded back to a hex nibble with a decimal-point bit. It serves as a self-checking monitor in board-level loopback tests and as a display-bus reader on a second board.

---
 rtl/sseg_pkg.sv | 30 +++
 rtl/sseg_to_hex.sv | 37 +++
 rtl/sseg_capture.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants for the seven-segment capture path
//   NUM_DIGITS    digits on the multiplexed bus
//   SEG_BLANK     all segments off (active-low)
//   AN_BLANK      no digit strobe asserted
//   GLYPH_0..F    active-low {g,f,e,d,c,b,a} patterns for hex 0..F
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_BLANK  = 4'hF;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/sseg_to_hex.sv
// rtl/sseg_to_hex.sv - combinational glyph-to-nibble decoder
//   glyph   in  7  active-low {g,f,e,d,c,b,a}
//   nibble  out 4  decoded hex value, 0 when glyph is not a hex glyph
//   ok      out 1  glyph is one of the 16 hex glyphs
module sseg_to_hex
  import sseg_pkg::*;
(
  input  logic [6:0] glyph,
  output logic [3:0] nibble,
  output logic       ok
);

  always_comb begin
    nibble = 4'h0;
    ok     = 1'b1;
    case (glyph)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_capture.sv
// rtl/sseg_capture.sv - captures and decodes a multiplexed four-digit display bus
//   clk         in  1   system clock
//   reset       in  1   synchronous, active-high
//   an          in  4   digit strobes, active-low
//   sseg        in  8   segments, active-low, [7] = dp
//   hex         out 16  decoded digits, digit k at [4k+3:4k]
//   dp          out 4   raw dp bit per digit
//   seg_ok      out 4   digit k holds a legal hex glyph
//   frame_tick  out 1   pulse when all four digits have been captured
//   an_err      out 1   pulse when a settled strobe is not one-hot-low
//   live        out 1   frame seen and no timeout since
module sseg_capture
  import sseg_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 262144,
  parameter int TO_W    = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [15:0] hex,
  output logic [3:0]  dp,
  output logic [3:0]  seg_ok,
  output logic        frame_tick,
  output logic        an_err,
  output logic        live
);

  localparam int ST_W = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(SETTLE - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  logic [11:0]                  in_r_q, in_r_d, in_p_q, in_p_d;
  logic [ST_W-1:0]              stab_q, stab_d;
  logic                         done_q, done_d;
  logic [NUM_DIGITS-1:0][6:0]   seg_q, seg_d;
  logic [NUM_DIGITS-1:0]        dp_raw_q, dp_raw_d;
  logic [NUM_DIGITS-1:0]        seen_q, seen_d;
  logic [TO_W-1:0]              to_cnt_q, to_cnt_d;
  logic                         frame_hit_q, frame_hit_d;
  logic                         err_hit_q, err_hit_d;
  logic [15:0]                  hex_q, hex_d;
  logic [3:0]                   dp_q, dp_d;
  logic [3:0]                   seg_ok_q, seg_ok_d;
  logic                         frame_tick_q, frame_tick_d;
  logic                         an_err_q, an_err_d;
  logic                         live_q, live_d;

  logic                         changed, settled, legal, capture;
  logic [1:0]                   idx;
  logic [NUM_DIGITS-1:0]        seen_next;
  logic [NUM_DIGITS-1:0][3:0]   nib;
  logic [NUM_DIGITS-1:0]        nib_ok;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    sseg_to_hex u_dec (
      .glyph  (seg_q[k]),
      .nibble (nib[k]),
      .ok     (nib_ok[k])
    );
  end

  always_comb begin
    in_r_d      = {an, sseg};
    in_p_d      = in_r_q;
    stab_d      = stab_q;
    done_d      = done_q;
    seg_d       = seg_q;
    dp_raw_d    = dp_raw_q;
    seen_d      = seen_q;
    seen_next   = seen_q;
    frame_hit_d = 1'b0;
    err_hit_d   = 1'b0;
    legal       = 1'b0;
    idx         = 2'd0;
    capture     = 1'b0;

    changed = (in_r_q != in_p_q);
    if (changed) begin
      stab_d = '0;
      done_d = 1'b0;
    end else if (stab_q != ST_MAX) begin
      stab_d = stab_q + 1'b1;
    end
    // The dwell acts on the edge where stab reaches its ceiling; done keeps a
    // long dwell from acting again while stab sits saturated.
    settled = !changed && (stab_d == ST_MAX) && !done_q;
    if (settled) done_d = 1'b1;

    case (in_p_q[11:8])
      4'b1110: begin legal = 1'b1; idx = 2'd0; end
      4'b1101: begin legal = 1'b1; idx = 2'd1; end
      4'b1011: begin legal = 1'b1; idx = 2'd2; end
      4'b0111: begin legal = 1'b1; idx = 2'd3; end
      default: legal = 1'b0;
    endcase

    capture   = settled && legal;
    err_hit_d = settled && !legal && (in_p_q[11:8] != AN_BLANK);

    if (capture) begin
      seg_d[idx]    = in_p_q[6:0];
      dp_raw_d[idx] = in_p_q[7];
      seen_next     = seen_q | (NUM_DIGITS'(1) << idx);
      if (seen_next == {NUM_DIGITS{1'b1}}) begin
        frame_hit_d = 1'b1;
        seen_d      = '0;
      end else begin
        seen_d = seen_next;
      end
    end

    if (capture)                 to_cnt_d = '0;
    else if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + 1'b1;
    else                         to_cnt_d = to_cnt_q;

    live_d = live_q;
    if (frame_hit_q) live_d = 1'b1;
    // to_cnt_d is zero whenever a capture happens, so a capture always wins.
    if (to_cnt_d == TO_MAX) begin
      live_d = 1'b0;
      seen_d = '0;
    end

    hex_d        = nib;
    dp_d         = dp_raw_q;
    seg_ok_d     = nib_ok;
    frame_tick_d = frame_hit_q;
    an_err_d     = err_hit_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_r_q       <= {AN_BLANK, 8'hFF};
      in_p_q       <= {AN_BLANK, 8'hFF};
      stab_q       <= '0;
      done_q       <= 1'b0;
      seg_q        <= {NUM_DIGITS{SEG_BLANK}};
      dp_raw_q     <= '0;
      seen_q       <= '0;
      to_cnt_q     <= '0;
      frame_hit_q  <= 1'b0;
      err_hit_q    <= 1'b0;
      hex_q        <= '0;
      dp_q         <= '0;
      seg_ok_q     <= '0;
      frame_tick_q <= 1'b0;
      an_err_q     <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      in_r_q       <= in_r_d;
      in_p_q       <= in_p_d;
      stab_q       <= stab_d;
      done_q       <= done_d;
      seg_q        <= seg_d;
      dp_raw_q     <= dp_raw_d;
      seen_q       <= seen_d;
      to_cnt_q     <= to_cnt_d;
      frame_hit_q  <= frame_hit_d;
      err_hit_q    <= err_hit_d;
      hex_q        <= hex_d;
      dp_q         <= dp_d;
      seg_ok_q     <= seg_ok_d;
      frame_tick_q <= frame_tick_d;
      an_err_q     <= an_err_d;
      live_q       <= live_d;
    end
  end

  assign hex        = hex_q;
  assign dp         = dp_q;
  assign seg_ok     = seg_ok_q;
  assign frame_tick = frame_tick_q;
  assign an_err     = an_err_q;
  assign live       = live_q;

endmodule
